weight_rom_stream_ctrl: RTL and testbench

- Sequencer between a parameter ROM (`<param>_rom`, fixed 2-cycle registered read latency, `ce0`-gated) and a downstream valid/ready weight consumer (e.g. linear/matmul block).
- Issues ROM addresses 0..OUT_DEPTH-1 for a programmable number of passes, tracks in-flight reads, and buffers returning data in a small FIFO.
- Uses read credits, so `data_out_ready` backpressure never drops or duplicates a beat.
- Reports per-job `busy`/`done` to the layer scheduler.

---
 rtl/weight_stream_pkg.sv | 10 +
 rtl/weight_stream_fifo.sv | 49 ++++
 rtl/weight_rom_stream_ctrl.sv | 114 +++++++++++
 tb/tb_weight_rom_stream_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/weight_stream_pkg.sv
// weight_stream_pkg: shared FSM state type and credit-width helper for the weight ROM streamer.
package weight_stream_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} wsc_state_t;

    function automatic int credit_width(input int fifo_depth, input int rom_latency);
        return $clog2(fifo_depth + rom_latency + 1);
    endfunction

endpackage

// File: rtl/weight_stream_fifo.sv
// weight_stream_fifo: registered show-ahead FIFO with occupancy count and synchronous flush.
module weight_stream_fifo #(
    parameter int WIDTH = 129,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic do_push, do_pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push && count != CW'(DEPTH);
    assign do_pop  = pop && count != '0;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= inc(wr_ptr);
            if (do_pop) rd_ptr <= inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/weight_rom_stream_ctrl.sv
// weight_rom_stream_ctrl: streams ROM words 0..OUT_DEPTH-1 for N passes to a valid/ready consumer,
// issuing reads only against free FIFO credits so backpressure never loses a beat.
module weight_rom_stream_ctrl
    import weight_stream_pkg::*;
#(
    parameter int DATA_WIDTH  = 128,
    parameter int OUT_DEPTH   = 2304,
    parameter int ADDR_WIDTH  = $clog2(OUT_DEPTH) + 1,
    parameter int ROM_LATENCY = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int PASS_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [PASS_WIDTH-1:0] num_passes,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [PASS_WIDTH-1:0] pass_idx,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  rom_ce,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    input  logic                  data_out_ready,
    output logic                  data_out_last
);
    localparam int CW = credit_width(FIFO_DEPTH, ROM_LATENCY);

    wsc_state_t state;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [PASS_WIDTH-1:0] pass_cnt, npass;
    logic [ROM_LATENCY-1:0] vld_sr, tag_sr;
    logic [CW-1:0] inflight, occ;
    logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_cnt;
    logic [DATA_WIDTH:0] fifo_q;
    logic pop, issue, tag, final_rd;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < ROM_LATENCY; i++) inflight = inflight + CW'(vld_sr[i]);
    end

    assign occ            = CW'(fifo_cnt);
    assign data_out_valid = fifo_cnt != '0;
    assign data_out       = fifo_q[DATA_WIDTH:1];
    assign data_out_last  = data_out_valid & fifo_q[0];
    assign pop            = data_out_valid & data_out_ready;
    // A slot being popped this cycle is already free for the read issued now.
    assign issue    = state == ISSUE && (inflight + occ < CW'(FIFO_DEPTH) + CW'(pop));
    assign tag      = addr_cnt == ADDR_WIDTH'(OUT_DEPTH - 1);
    assign final_rd = issue && tag && pass_cnt == npass - 1'b1;
    assign rom_addr = addr_cnt;
    assign rom_ce   = 1'b1;
    assign pass_idx = pass_cnt;

    weight_stream_fifo #(.WIDTH(DATA_WIDTH + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (abort),
        .push  (vld_sr[ROM_LATENCY-1]),
        .pop   (pop),
        .din   ({rom_q, tag_sr[ROM_LATENCY-1]}),
        .dout  (fifo_q),
        .count (fifo_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            addr_cnt <= '0;
            pass_cnt <= '0;
            npass    <= '0;
            vld_sr   <= '0;
            tag_sr   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done   <= 1'b0;
            vld_sr <= abort ? '0 : (vld_sr << 1) | ROM_LATENCY'(issue);
            tag_sr <= abort ? '0 : (tag_sr << 1) | ROM_LATENCY'(issue & tag);
            if (abort) begin
                state    <= IDLE;
                busy     <= 1'b0;
                addr_cnt <= '0;
                pass_cnt <= '0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        npass    <= num_passes;
                        addr_cnt <= '0;
                        pass_cnt <= '0;
                        state    <= num_passes == '0 ? DONE : ISSUE;
                        busy     <= num_passes != '0;
                        done     <= num_passes == '0;
                    end
                    ISSUE: if (issue) begin
                        addr_cnt <= tag ? '0 : addr_cnt + 1'b1;
                        if (tag && !final_rd) pass_cnt <= pass_cnt + 1'b1;
                        if (final_rd) state <= DRAIN;
                    end
                    DRAIN: if (inflight == '0 && (occ == '0 || (occ == CW'(1) && pop))) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_weight_rom_stream_ctrl.sv
// tb_weight_rom_stream_ctrl: drives directed and random jobs against an identity ROM and checks
// every cycle against a queue-based model of the expected beat stream, busy and done.
module tb_weight_rom_stream_ctrl;
    localparam int DW = 16;
    localparam int OD = 8;
    localparam int AW = 4;
    localparam int PW = 16;
    localparam int FD = 4;

    logic clk = 1'b0;
    logic rst, start, abort, busy, done, rom_ce, data_out_valid, data_out_ready, data_out_last;
    logic [PW-1:0] num_passes, pass_idx;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_q, rom_s1, data_out;

    always #5 clk = ~clk;

    // Identity ROM with two registered stages: word[i] = i.
    always @(posedge clk) begin
        rom_s1 <= DW'(rom_addr);
        rom_q  <= rom_s1;
    end

    weight_rom_stream_ctrl #(
        .DATA_WIDTH(DW), .OUT_DEPTH(OD), .ROM_LATENCY(2), .FIFO_DEPTH(FD), .PASS_WIDTH(PW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_passes(num_passes), .abort(abort),
        .busy(busy), .done(done), .pass_idx(pass_idx), .rom_addr(rom_addr), .rom_ce(rom_ce),
        .rom_q(rom_q), .data_out(data_out), .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready), .data_out_last(data_out_last)
    );

    typedef struct {logic [DW-1:0] d; bit last; int pass;} beat_t;
    beat_t exp_q[$];
    int compared = 0, mismatched = 0, cyc = 0, hs_count = 0, acc_cyc = 0, done_cyc = 0;
    int pmax = 0, rmode = 0, phase = 0, h0 = 0;
    bit m_idle = 1, exp_busy = 0, exp_done = 0, first_seen = 0, prev_stall = 0, rval = 1;
    logic [DW-1:0] prev_d;
    logic prev_last;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cycle_check();
        bit nd, nb;
        beat_t b;
        cyc++;
        if (!rst) begin
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_valid", data_out_valid, 0);
            check("rst_pass_idx", pass_idx, 0);
            exp_q.delete();
            m_idle = 1; exp_busy = 0; exp_done = 0; prev_stall = 0;
            return;
        end
        nd = 0;
        nb = exp_busy;
        check("busy", busy, exp_busy);
        check("done", done, exp_done);
        check("fifo_occupancy_bound", dut.u_fifo.count <= FD, 1);
        if (done) done_cyc = cyc;
        if (busy && int'(pass_idx) > pmax) pmax = int'(pass_idx);
        if (prev_stall) begin
            check("hold_valid", data_out_valid, 1);
            check("hold_data", data_out, prev_d);
            check("hold_last", data_out_last, prev_last);
        end
        if (data_out_valid && exp_q.size() == 0) check("spurious_valid", data_out_valid, 0);
        else if (data_out_valid) begin
            if (!first_seen) begin
                first_seen = 1;
                check("first_valid_latency", cyc - acc_cyc, 4);
            end
            if (data_out_ready) begin
                b = exp_q.pop_front();
                hs_count++;
                check("data", data_out, b.d);
                check("last", data_out_last, b.last);
                check("pass_idx_window", int'(pass_idx) == b.pass || int'(pass_idx) == b.pass + 1, 1);
                if (exp_q.size() == 0) begin
                    nd = 1;
                    nb = 0;
                end
            end
        end else if (rmode == 0 && first_seen && exp_q.size() != 0) check("bubble", data_out_valid, 1);
        prev_stall = data_out_valid && !data_out_ready && exp_q.size() != 0;
        prev_d = data_out;
        prev_last = data_out_last;
        if (abort && !m_idle) begin
            exp_q.delete();
            nd = 0; nb = 0; m_idle = 1; prev_stall = 0;
        end else if (start && !abort && m_idle) begin
            acc_cyc = cyc; first_seen = 0; pmax = 0;
            if (num_passes == 0) nd = 1;
            else begin
                nb = 1;
                for (int p = 0; p < int'(num_passes); p++)
                    for (int a = 0; a < OD; a++) exp_q.push_back('{d: DW'(a), last: (a == OD - 1), pass: p});
            end
            m_idle = 0;
        end
        if (exp_done) m_idle = 1;
        exp_done = nd;
        exp_busy = nb;
    endtask

    task automatic step();
        @(negedge clk);
        cycle_check();
        @(posedge clk);
        #1;
        case (rmode)
            0: data_out_ready = 1'b1;
            1: begin data_out_ready = (phase % 4 == 0) || (phase % 4 == 3); phase++; end
            2: data_out_ready = 1'($urandom_range(0, 1));
            default: data_out_ready = rval;
        endcase
    endtask

    task automatic wait_idle(input int max);
        for (int i = 0; i < max && !m_idle; i++) step();
        check("idle_timeout", m_idle, 1);
    endtask

    task automatic run_job(input int np);
        h0 = hs_count;
        start = 1'b1;
        num_passes = PW'(np);
        step();
        start = 1'b0;
        wait_idle(300);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0; num_passes = '0; data_out_ready = 1'b1;
        repeat (2) step();
        check("rst_rom_ce", rom_ce, 1);
        check("rst_rom_addr", rom_addr, 0);
        rst = 1'b1;
        step();

        run_job(1);
        check("basic_beats", hs_count - h0, 8);
        check("basic_done_cycle", done_cyc - acc_cyc, 12);

        run_job(3);
        check("multi_beats", hs_count - h0, 24);
        check("multi_done_cycle", done_cyc - acc_cyc, 28);
        check("multi_max_pass", pmax, 2);

        rmode = 1;
        run_job(2);
        check("bp_beats", hs_count - h0, 16);
        check("bp_max_pass", pmax, 1);
        rmode = 0;

        run_job(0);
        check("zero_beats", hs_count - h0, 0);
        check("zero_done_cycle", done_cyc - acc_cyc, 1);

        h0 = hs_count;
        start = 1'b1; num_passes = 1; step(); start = 1'b0;
        step(); step();
        start = 1'b1; num_passes = 5; step(); start = 1'b0;
        wait_idle(300);
        check("ignored_start_beats", hs_count - h0, 8);

        rmode = 3; rval = 1;
        h0 = hs_count;
        start = 1'b1; num_passes = 1; step(); start = 1'b0;
        for (int i = 0; i < 50 && hs_count - h0 < 3; i++) step();
        check("abort_reached_beat3", hs_count - h0, 3);
        rval = 0; data_out_ready = 1'b0;
        step(); step();
        abort = 1'b1; step(); abort = 1'b0;
        check("abort_valid", data_out_valid, 0);
        check("abort_busy", busy, 0);
        repeat (6) step();
        rmode = 0;
        run_job(1);
        check("post_abort_beats", hs_count - h0, 8);
        check("post_abort_done_cycle", done_cyc - acc_cyc, 12);

        rmode = 3; rval = 1;
        h0 = hs_count;
        start = 1'b1; num_passes = 2; step(); start = 1'b0;
        for (int i = 0; i < 50 && hs_count - h0 < 5; i++) step();
        check("reset_reached_beat5", hs_count - h0, 5);
        rval = 0; data_out_ready = 1'b0;
        step(); step();
        #1 rst = 1'b0;
        #1;
        check("async_busy", busy, 0);
        check("async_done", done, 0);
        check("async_valid", data_out_valid, 0);
        check("async_last", data_out_last, 0);
        check("async_rom_addr", rom_addr, 0);
        check("async_pass_idx", pass_idx, 0);
        check("async_rom_ce", rom_ce, 1);
        step(); step();
        rst = 1'b1;
        step();
        rmode = 0;
        run_job(1);
        check("post_reset_beats", hs_count - h0, 8);
        check("post_reset_done_cycle", done_cyc - acc_cyc, 12);

        for (int j = 0; j < 8; j++) begin
            rmode = 2;
            start = 1'b1;
            num_passes = PW'($urandom_range(1, 3));
            step();
            start = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(2, 20)) step();
                abort = 1'b1; step(); abort = 1'b0;
            end
            wait_idle(400);
        end
        rmode = 0;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
